// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
    localparam logic [31:0] NOP_INSN          = 32'h00000013;

endpackage

// File: rtl/imem_word_packer.sv
// Packs four accepted bytes, least significant first, into one 32-bit word.
module imem_word_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_count;
    logic [23:0] shift_reg;

    // Only the first three bytes are stored; the fourth is merged combinationally
    // so the full word is available on the same edge that accepts its last byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_count <= '0;
            shift_reg  <= '0;
        end else if (clear) begin
            byte_count <= '0;
            shift_reg  <= '0;
        end else if (byte_valid) begin
            byte_count <= byte_count + 2'd1;
            shift_reg  <= {byte_data, shift_reg[23:8]};
        end
    end

    assign word       = {byte_data, shift_reg};
    assign word_valid = byte_valid && (byte_count == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream boot loader: writes a checksum-verified program image into
// instruction memory and holds the core in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         IMEM_DEPTH = 512,
    parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             insMemEn,
    output logic [WIDTH-1:0] insMemAddr,
    output logic [WIDTH-1:0] insMemDataIn,
    output logic             cpu_reset,
    output logic             done,
    output logic             error,
    output logic [15:0]      words_loaded
);

    loader_state_t    state, state_next;
    logic [15:0]      frame_len, len_next, len_candidate;
    logic [7:0]       csum, csum_next;
    logic             en_next, cpu_reset_next, done_next, error_next;
    logic [WIDTH-1:0] addr_next, data_next;
    logic [15:0]      words_next;
    logic             accept, sync_accept, pack_clear;
    logic [31:0]      packed_word;
    logic             word_valid;

    assign rx_ready      = reset_n && (state != WRITE);
    assign accept        = rx_valid && rx_ready;
    assign sync_accept   = accept && (rx_data == SYNC_BYTE);
    assign len_candidate = {rx_data, frame_len[7:0]};

    imem_word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pack_clear),
        .byte_valid (accept && (state == DATA)),
        .byte_data  (rx_data),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Address and data only move on WRITE entry or SYNC, since the core
    // samples the write port on every clock while insMemEn is high.
    always_comb begin
        state_next     = state;
        en_next        = insMemEn;
        addr_next      = insMemAddr;
        data_next      = insMemDataIn;
        cpu_reset_next = cpu_reset;
        done_next      = done;
        error_next     = error;
        words_next     = words_loaded;
        csum_next      = csum;
        len_next       = frame_len;
        pack_clear     = 1'b0;

        case (state)
            IDLE, ERR: begin
            end
            DONE: begin
                cpu_reset_next = 1'b0;
            end
            LEN0: begin
                if (accept) begin
                    len_next[7:0] = rx_data;
                    csum_next     = csum ^ rx_data;
                    state_next    = LEN1;
                end
            end
            LEN1: begin
                if (accept) begin
                    len_next  = len_candidate;
                    csum_next = csum ^ rx_data;
                    if (len_candidate > 16'(IMEM_DEPTH)) begin
                        state_next = ERR;
                        en_next    = 1'b0;
                        error_next = 1'b1;
                    end else if (len_candidate == 16'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    csum_next = csum ^ rx_data;
                    if (word_valid) begin
                        data_next  = WIDTH'(packed_word);
                        addr_next  = WIDTH'(words_loaded);
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                words_next = words_loaded + 16'd1;
                state_next = ((words_loaded + 16'd1) == frame_len) ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) begin
                    en_next = 1'b0;
                    if (rx_data == csum) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = ERR;
                        error_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A new frame may start from any resting state and overrides its defaults.
        if (sync_accept && ((state == IDLE) || (state == DONE) || (state == ERR))) begin
            state_next     = LEN0;
            en_next        = 1'b1;
            cpu_reset_next = 1'b1;
            done_next      = 1'b0;
            error_next     = 1'b0;
            words_next     = '0;
            csum_next      = '0;
            addr_next      = '0;
            data_next      = WIDTH'(NOP_INSN);
            pack_clear     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            insMemEn     <= 1'b0;
            insMemAddr   <= '0;
            insMemDataIn <= WIDTH'(NOP_INSN);
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            csum         <= '0;
            frame_len    <= '0;
        end else begin
            insMemEn     <= en_next;
            insMemAddr   <= addr_next;
            insMemDataIn <= data_next;
            cpu_reset    <= cpu_reset_next;
            done         <= done_next;
            error        <= error_next;
            words_loaded <= words_next;
            csum         <= csum_next;
            frame_len    <= len_next;
        end
    end

endmodule
